// File: rtl/encoder_8_3_seq_pkg.sv
// Shared constants and FSM state type for the sequential 8-to-3 encoder.
// The top module and the priority finder both import this package.
package encoder_pkg;

   localparam int N = 8;
   localparam int W = 3;

   typedef enum logic [1:0] {
      IDLE,
      SERVE,
      EMPTY
   } enc_state_t;

endpackage

// File: rtl/encoder_8_3_seq_prio.sv
// Combinational lowest-set-bit finder. It reports the index of the lowest set bit,
// whether any bit is set, and whether exactly one bit is set.
module prio_enc_8_3
   import encoder_pkg::*;
(
   input  logic [N-1:0] pending,
   output logic [W-1:0] code,
   output logic         any,
   output logic         single
);

   // The scan runs from the top bit down, so the lowest set bit is the last one written.
   always_comb begin
      code = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pending[i]) begin
            code = W'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves zero only when exactly one bit was set.
   assign any    = |pending;
   assign single = any && ((pending & (pending - N'(1))) == '0);

endmodule

// File: rtl/encoder_8_3_seq.sv
// Sequential 8-to-3 encoder: accepts a request vector and emits the index of each set bit,
// one per beat, lowest first. An all-zero vector produces a single "none" beat.
module encoder_8_3_seq #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_code,
   output logic         out_last,
   output logic         out_none
);

   import encoder_pkg::*;

   enc_state_t   state;
   enc_state_t   state_next;
   logic [N-1:0] pending;
   logic [N-1:0] pending_next;
   logic [W-1:0] low_code;
   logic         low_any;
   logic         low_single;

   prio_enc_8_3 u_prio (
      .pending (pending),
      .code    (low_code),
      .any     (low_any),
      .single  (low_single)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pending <= '0;
      end else begin
         state   <= state_next;
         pending <= pending_next;
      end
   end

   // Outputs depend only on state and pending, so they hold while the consumer stalls.
   always_comb begin
      state_next   = state;
      pending_next = pending;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_code     = '0;
      out_last     = 1'b0;
      out_none     = 1'b0;

      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               pending_next = in_vec;
               state_next   = (|in_vec) ? SERVE : EMPTY;
            end
         end
         SERVE: begin
            out_valid = 1'b1;
            out_code  = low_code;
            out_last  = low_single;
            if (out_ready) begin
               pending_next = pending & ~(N'(1) << low_code);
               if (low_single || !low_any) begin
                  state_next = IDLE;
               end
            end
         end
         EMPTY: begin
            out_valid = 1'b1;
            out_none  = 1'b1;
            out_last  = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
